// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch widths and the {pc, instr} entry type handed to decode
package fetch_pkg;
   localparam int XLEN = 32;
   localparam int ILEN = 32;
   localparam int FETCH_FIFO_DEPTH = 2;
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_skid_fifo.sv
// fetch_skid_fifo: 2-entry FIFO of fetch entries; flush overrides push and pop
module fetch_skid_fifo
   import fetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t din,
   output fetch_entry_t dout,
   output logic [1:0]   count
);
   fetch_entry_t mem [FETCH_FIFO_DEPTH];
   logic rd_q, wr_q;
   assign dout = mem[rd_q];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         rd_q   <= 1'b0;
         wr_q   <= 1'b0;
         count  <= 2'd0;
      end else if (flush) begin
         rd_q  <= 1'b0;
         wr_q  <= 1'b0;
         count <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_q] <= din;
            wr_q      <= !wr_q;
         end
         if (pop) rd_q <= !rd_q;
         count <= count + 2'(push) - 2'(pop);
      end
   end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the fetch PC, issues iCache reads and queues returned words for decode
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int              ADDR_WIDTH = 9,
   parameter int              DATA_WIDTH = ILEN,
   parameter logic [XLEN-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  redirect_valid,
   input  logic [XLEN-1:0]       redirect_pc,
   output logic [ADDR_WIDTH-1:0] icache_addr,
   input  logic [DATA_WIDTH-1:0] icache_rdata,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [XLEN-1:0]       out_pc,
   output logic [DATA_WIDTH-1:0] out_instr
);
   logic [XLEN-1:0] pc_q, inflight_pc_q;
   logic            inflight_q, pop, issue;
   logic [1:0]      count;
   logic [2:0]      load;
   fetch_entry_t    head, arrival;
   assign pop         = out_valid & out_ready;
   // a slot stays reserved for the outstanding read so the FIFO can never overflow
   assign load        = 3'(count) + 3'(inflight_q) - 3'(pop);
   assign issue       = !redirect_valid && load <= 3'd1;
   assign icache_addr = pc_q[ADDR_WIDTH+1:2];
   assign out_valid   = count != 2'd0;
   assign out_pc      = head.pc;
   assign out_instr   = head.instr;
   assign arrival     = '{pc: inflight_pc_q, instr: icache_rdata};
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else if (redirect_valid) begin
         pc_q       <= redirect_pc & ~XLEN'(3);
         inflight_q <= 1'b0;
      end else if (issue) begin
         pc_q          <= pc_q + XLEN'(4);
         inflight_q    <= 1'b1;
         inflight_pc_q <= pc_q;
      end else begin
         inflight_q <= 1'b0;
      end
   end
   fetch_skid_fifo u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (inflight_q & !redirect_valid),
      .pop   (pop & !redirect_valid),
      .flush (redirect_valid),
      .din   (arrival),
      .dout  (head),
      .count (count)
   );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random fetch/stall/redirect traffic against an in-order stream model
module tb_fetch_unit;
   localparam logic [31:0] RESET_PC = 32'h7F8;
   logic        clk, rst, redirect_valid, out_valid, out_ready;
   logic [31:0] redirect_pc, out_pc, out_instr, icache_rdata;
   logic [8:0]  icache_addr;
   logic [31:0] rom [512];
   int n_checks = 0, n_fail = 0;
   logic [31:0] exp_pc, held_pc, held_instr;
   int since;
   logic hold;

   fetch_unit #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .icache_addr(icache_addr), .icache_rdata(icache_rdata), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) icache_rdata <= rom[icache_addr];

   function automatic logic [31:0] word_at(input logic [31:0] pc);
      return 32'hA000_0000 + 32'(pc[10:2]);
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Stream model: after a reset or redirect nothing shows for two cycles, then the
   // stream never gaps; every accepted entry is the next sequential PC.
   always @(negedge clk) begin
      if (rst) begin
         check("rst_valid", 64'(out_valid), 64'd0);
         check("rst_pc", 64'(out_pc), 64'd0);
         check("rst_instr", 64'(out_instr), 64'd0);
         exp_pc = RESET_PC;
         since  = 0;
         hold   = 1'b0;
      end else begin
         if (since < 3) since++;
         check("valid", 64'(out_valid), 64'(since == 3));
         if (hold) begin
            check("hold_pc", 64'(out_pc), 64'(held_pc));
            check("hold_instr", 64'(out_instr), 64'(held_instr));
         end
         if (redirect_valid) begin
            exp_pc = redirect_pc & ~32'h3;
            since  = 0;
            hold   = 1'b0;
         end else begin
            if (out_valid && out_ready) begin
               check("pc", 64'(out_pc), 64'(exp_pc));
               check("instr", 64'(out_instr), 64'(word_at(exp_pc)));
               exp_pc = exp_pc + 32'd4;
            end
            hold       = out_valid && !out_ready;
            held_pc    = out_pc;
            held_instr = out_instr;
         end
      end
   end

   task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
      out_ready      = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n, input logic rdy);
      for (int i = 0; i < n; i++) step(rdy, 1'b0, 32'h0);
   endtask

   initial begin
      for (int i = 0; i < 512; i++) rom[i] = 32'hA000_0000 + 32'(i);
      rst = 1'b1;
      out_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      run(10, 1'b1);
      step(1'b1, 1'b1, 32'h0);
      run(5, 1'b1);
      run(6, 1'b0);
      run(8, 1'b1);
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 32'h100);
      run(6, 1'b1);
      run(3, 1'b0);
      step(1'b0, 1'b1, 32'h100);
      run(6, 1'b1);
      step(1'b1, 1'b1, 32'h103);
      run(6, 1'b1);
      step(1'b1, 1'b1, 32'h7F0);
      run(8, 1'b1);
      step(1'b1, 1'b1, 32'hFFFF_FFF8);
      run(6, 1'b1);
      step(1'b1, 1'b1, 32'h200);
      step(1'b1, 1'b1, 32'h300);
      step(1'b1, 1'b1, 32'h404);
      run(6, 1'b1);
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom);
      run(5, 1'b1);
      run(4, 1'b0);
      rst = 1'b1;
      #1;
      check("async_rst_valid", 64'(out_valid), 64'd0);
      check("async_rst_pc", 64'(out_pc), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      run(8, 1'b1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
